end_accumulator: RTL and testbench
==================================

Name: end_accumulator

Overview:
- Final reduction stage of the matrix-multiply datapath. Sits after the last PE of each systolic row.
- Per cycle, per lane, it adds the incoming partial sum and product into a running accumulator.
- It accumulates over a programmable K-length dot product and emits one result vector per K beats.
- Uses a valid/ready handshake on both sides and holds the result under backpressure.

Parameters:
- DWIDTH, 32: signed two's-complement width of sum_in, prod_in, accumulator and result, per lane.
- LANES, 4: number of independent accumulation lanes (matrix columns).
- KW, 8: width of the K-length field; max K = 2^KW-1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous abort of the in-flight accumulation
- k_len  in  KW  beats per result; sampled on the first beat of each result; 0 is treated as 1
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- sum_in  in  LANES*DWIDTH  packed partial sums; lane i = bits [i*DWIDTH +: DWIDTH]
- prod_in  in  LANES*DWIDTH  packed products, same packing
- out_valid  out  1  result vector valid
- out_ready  in  1  consumer accepts the result
- out_data  out  LANES*DWIDTH  packed accumulated results
- out_ovf  out  LANES  per-lane overflow flag for the presented result
- busy  out  1  high in state ACCUM

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - state = IDLE; acc = 0; cnt = 0; k_lat = 0.
  - out_valid = 0, out_data = 0, out_ovf = 0, busy = 0.
- Ready rule: in_ready = !(out_valid && !out_ready). The input stalls only while an unconsumed result is held. This is combinational from out_ready.
- Beat accepted: per lane, term = sum_in + prod_in, computed at DWIDTH+2 bits with sign extension. This is added to acc, also kept at DWIDTH+2 bits.
- FSM states: IDLE, ACCUM.
  - IDLE, beat accepted:
    - Latch k_lat = max(k_len, 1).
    - If k_lat == 1, load the result directly and stay in IDLE.
    - Otherwise acc = term, cnt = 1, go to ACCUM.
  - ACCUM, beat accepted, cnt < k_lat-1: acc += term; cnt++.
  - ACCUM, beat accepted, cnt == k_lat-1 (last beat):
    - Result = acc + term, loaded to the output register.
    - out_valid <= 1; acc = 0; cnt = 0; go to IDLE.
  - ACCUM, no beat: hold all state; bubbles are allowed.
- Latency: last beat accepted in cycle N -> out_valid = 1 in cycle N+1. Throughput is one beat per cycle.
- Output hold:
  - out_data and out_ovf stay stable while out_valid && !out_ready.
  - out_valid clears on out_ready unless a new result loads in the same cycle.
  - Load and consume in the same cycle: the new result replaces the old one and out_valid stays 1.
- Result narrowing: the DWIDTH+2 result is reduced to DWIDTH per lane (see Optional Feature). A lane overflows when its top 3 bits are not all equal.
- clear:
  - acc = 0, cnt = 0, state = IDLE.
  - A beat arriving in the same cycle is consumed and dropped.
  - A pending out_valid result is NOT dropped.
  - clear has priority over accumulation.
- Reset mid-accumulation discards everything, including a pending output.
- k_len changes during ACCUM are ignored until the next IDLE first beat.

Optional Feature:
- Macro: END_ACC_SATURATE_EN.
- Defined: each overflowing lane clamps to the most positive (2^(DWIDTH-1)-1) or most negative (-2^(DWIDTH-1)) value according to the sign bit of the wide result. The matching out_ovf bit = 1.
- Not defined: the wide result is truncated to the low DWIDTH bits (wrap). out_ovf = 0 always; the port stays present.

Decomposition:
- Shared package/defines file: DWIDTH default, state encoding constants (IDLE, ACCUM), and GUARD = 2 for the extra accumulator bits.
- Natural sub-module: end_acc_lane. It holds one lane's term add, accumulator register, and narrowing/saturation logic, with load/accumulate/clear controls driven from the shared FSM/counter in end_accumulator. end_accumulator instantiates LANES copies via generate.

Test Plan:
- Single-beat result: k_len=0, lane0 sum_in=5, prod_in=7 -> cycle+1 out_valid=1, lane0 out_data=12, busy never asserts.
- K=4 with bubbles: lane1 inputs (1,2),(3,4),(5,6),(7,8), 2 idle cycles interleaved -> out_valid exactly once, lane1 = 36, one cycle after the 4th beat.
- Backpressure: out_ready=0 for 5 cycles after the result -> out_data stable, in_ready=0 and beats not consumed; out_ready=1 -> released, in_ready=1 the next cycle. Back-to-back K=2 results with out_ready=1 -> results every 2 cycles, no gaps.
- Overflow with DWIDTH=8, K=2, lane0 (100,27),(100,27) = 254:
  - END_ACC_SATURATE_EN defined -> out_data = 127, out_ovf[0] = 1.
  - Not defined -> out_data = -2 (0xFE), out_ovf = 0.
  - Negative case (-100,-28)x2 with saturation -> -128.
- clear at cnt=2 of K=4 while a previous result is pending with out_ready=0 -> pending result still presented intact; the next 4 beats produce a fresh, uncorrupted sum.
- rst_n pulsed low mid-ACCUM with out_valid=1 -> out_valid=0 and out_data=0 immediately (asynchronous); next K beats accumulate from zero.

Source files
------------

// File: rtl/end_accumulator_pkg.sv
// end_accumulator shared types and constants.
// Guard width, default sizes and FSM encoding.
package end_accumulator_pkg;

  localparam int DWIDTH_DEF = 32;
  localparam int LANES_DEF  = 4;
  localparam int KW_DEF     = 8;
  localparam int GUARD      = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

endpackage

// File: rtl/end_accumulator_if.sv
// end_accumulator beat/result handshake bundle.
// master drives beats and ready, slave is the accumulator.
interface end_accumulator_if #(
  parameter int DWIDTH = 32,
  parameter int LANES  = 4,
  parameter int KW     = 8
);

  logic                    clear;
  logic [KW-1:0]           k_len;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DWIDTH-1:0] sum_in;
  logic [LANES*DWIDTH-1:0] prod_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*DWIDTH-1:0] out_data;
  logic [LANES-1:0]        out_ovf;
  logic                    busy;

  modport master (
    output clear,
    output k_len,
    output in_valid,
    output sum_in,
    output prod_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_ovf,
    input  busy
  );

  modport slave (
    input  clear,
    input  k_len,
    input  in_valid,
    input  sum_in,
    input  prod_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_ovf,
    output busy
  );

endinterface

// File: rtl/end_accumulator_lane.sv
// One accumulation lane: wide add, accumulator, narrowing.
// END_ACC_SATURATE_EN selects clamping instead of wrap.
module end_acc_lane
  import end_accumulator_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              beat,
  input  logic              start,
  input  logic              load,
  input  logic [DWIDTH-1:0] sum_in,
  input  logic [DWIDTH-1:0] prod_in,
  output logic [DWIDTH-1:0] res,
  output logic              ovf
);

  localparam int WW = DWIDTH + GUARD;

  logic [WW-1:0]     term;
  logic [WW-1:0]     acc;
  logic [WW-1:0]     nxt;
  logic [DWIDTH-1:0] nar;
  logic              nar_ovf;

  // Sign-extended term and running sum; first beat restarts.
  always_comb begin
    term = {{GUARD{sum_in[DWIDTH-1]}}, sum_in}
         + {{GUARD{prod_in[DWIDTH-1]}}, prod_in};
    nxt  = start ? term : acc + term;
  end

`ifdef END_ACC_SATURATE_EN
  logic wide_ovf;

  // Clamp when the guard bits disagree with the sign.
  always_comb begin
    wide_ovf = (nxt[WW-1:DWIDTH-1] != {3{nxt[WW-1]}});
    nar_ovf  = wide_ovf;
    nar      = nxt[DWIDTH-1:0];
    if (wide_ovf) begin
      nar = nxt[WW-1] ? {1'b1, {(DWIDTH-1){1'b0}}}
                      : {1'b0, {(DWIDTH-1){1'b1}}};
    end
  end
`else
  // Plain wrap to the low bits; no overflow report.
  always_comb begin
    nar     = nxt[DWIDTH-1:0];
    nar_ovf = 1'b0;
  end
`endif

  // Accumulator: abort, restart after a result, or add.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (beat) begin
      acc <= load ? '0 : nxt;
    end
  end

  // Result register holds until the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res <= '0;
      ovf <= 1'b0;
    end else if (load) begin
      res <= nar;
      ovf <= nar_ovf;
    end
  end

endmodule

// File: rtl/end_accumulator.sv
// Row-end K-beat dot-product accumulator, LANES wide.
// Optional clamping via END_ACC_SATURATE_EN.
module end_accumulator
  import end_accumulator_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int LANES  = LANES_DEF,
  parameter int KW     = KW_DEF
) (
  input logic               clk,
  input logic               rst_n,
  end_accumulator_if.slave  bus
);

  state_t            state;
  logic [KW-1:0]     cnt;
  logic [KW-1:0]     k_lat;
  logic [KW-1:0]     k_eff;
  logic              out_valid;
  logic              in_ready;
  logic              fire;
  logic              beat;
  logic              first;
  logic              finish;
  logic              load;
  logic [DWIDTH-1:0] res_w [LANES];
  logic              ovf_w [LANES];

  assign in_ready = !(out_valid && !bus.out_ready);
  assign fire     = bus.in_valid && in_ready;
  assign beat     = fire && !bus.clear;
  assign first    = (state == IDLE);

  // Effective K and last-beat detect for this cycle.
  always_comb begin
    k_eff  = (bus.k_len == '0) ? KW'(1) : bus.k_len;
    finish = first ? (k_eff == KW'(1))
                   : (cnt == k_lat - KW'(1));
  end

  assign load = beat && finish;

  // Beat counter FSM plus result-valid tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      k_lat     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid <= 1'b0;
      end
      if (bus.clear) begin
        state <= IDLE;
        cnt   <= '0;
      end else if (fire) begin
        unique case (state)
          IDLE: begin
            k_lat <= k_eff;
            if (!finish) begin
              cnt   <= KW'(1);
              state <= ACCUM;
            end
          end
          ACCUM: begin
            if (finish) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt + KW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    end_acc_lane #(
      .DWIDTH (DWIDTH)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (bus.clear),
      .beat    (beat),
      .start   (first),
      .load    (load),
      .sum_in  (bus.sum_in[g*DWIDTH +: DWIDTH]),
      .prod_in (bus.prod_in[g*DWIDTH +: DWIDTH]),
      .res     (res_w[g]),
      .ovf     (ovf_w[g])
    );
  end

  // Pack per-lane results onto the output bus.
  always_comb begin
    bus.out_data = '0;
    bus.out_ovf  = '0;
    for (int i = 0; i < LANES; i++) begin
      bus.out_data[i*DWIDTH +: DWIDTH] = res_w[i];
      bus.out_ovf[i]                   = ovf_w[i];
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.busy      = (state == ACCUM);

endmodule

// File: tb/tb_end_accumulator.sv
// Scoreboard bench for end_accumulator (DWIDTH=8).
// Expected results follow END_ACC_SATURATE_EN.
module tb_end_accumulator;

  localparam int DW = 8;
  localparam int LN = 4;
  localparam int KW = 8;
  localparam longint MAXV = (64'sd1 <<< (DW-1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (DW-1));

  typedef struct packed {
    logic [LN*DW-1:0] data;
    logic [LN-1:0]    ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  res_t q[$];
  longint macc [LN];
  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  end_accumulator_if #(.DWIDTH(DW), .LANES(LN), .KW(KW)) bus ();

  end_accumulator #(
    .DWIDTH (DW),
    .LANES  (LN),
    .KW     (KW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  function automatic res_t model();
    res_t r;
    longint v;
    r = '0;
    for (int i = 0; i < LN; i++) begin
      v = macc[i];
`ifdef END_ACC_SATURATE_EN
      if (v > MAXV) begin
        r.data[i*DW +: DW] = DW'(MAXV);
        r.ovf[i] = 1'b1;
      end else if (v < MINV) begin
        r.data[i*DW +: DW] = DW'(MINV);
        r.ovf[i] = 1'b1;
      end else begin
        r.data[i*DW +: DW] = v[DW-1:0];
      end
`else
      r.data[i*DW +: DW] = v[DW-1:0];
`endif
    end
    return r;
  endfunction

  function automatic logic [LN*DW-1:0] lane(input int i, input int v);
    logic [LN*DW-1:0] r;
    r = '0;
    r[i*DW +: DW] = DW'(v);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_model();
    for (int i = 0; i < LN; i++) macc[i] = 0;
  endtask

  task automatic idle_in();
    bus.in_valid = 1'b0;
    bus.clear    = 1'b0;
    bus.sum_in   = '0;
    bus.prod_in  = '0;
    bus.k_len    = '0;
  endtask

  task automatic send_beat(input logic [LN*DW-1:0] s,
                           input logic [LN*DW-1:0] p,
                           input logic [KW-1:0] k,
                           input bit last,
                           output int waits);
    bus.sum_in   = s;
    bus.prod_in  = p;
    bus.k_len    = k;
    bus.in_valid = 1'b1;
    waits = 0;
    while (!bus.in_ready && waits < 40) begin
      step();
      waits++;
    end
    if (waits >= 40) begin
      n_run++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready=%b want 1", bus.in_ready);
    end
    for (int i = 0; i < LN; i++)
      macc[i] += longint'($signed(s[i*DW +: DW]))
               + longint'($signed(p[i*DW +: DW]));
    if (last) begin
      q.push_back(model());
      zero_model();
    end
    step();
    bus.in_valid = 1'b0;
  endtask

  always @(negedge clk) begin : mon
    res_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      n_run++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_extra: got data=%h ovf=%b want none",
                 bus.out_data, bus.out_ovf);
      end else begin
        e = q.pop_front();
        if ({bus.out_data, bus.out_ovf} !== e) begin
          n_fail++;
          $display("FAIL sb_result: got data=%h ovf=%b want data=%h ovf=%b",
                   bus.out_data, bus.out_ovf, e.data, e.ovf);
        end
      end
    end
  end

  task automatic test_reset();
    idle_in();
    bus.out_ready = 1'b1;
    zero_model();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    n_run++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_valid: got %b want 0", bus.out_valid);
    end
    n_run++;
    if (bus.out_data !== '0 || bus.out_ovf !== '0) begin
      n_fail++; $display("FAIL rst_data: got %h/%b want 0", bus.out_data, bus.out_ovf);
    end
    n_run++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_ctrl: got busy=%b rdy=%b want 0/1", bus.busy, bus.in_ready);
    end
  endtask

  task automatic test_single();
    int w;
    bus.out_ready = 1'b1;
    send_beat(lane(0, 5), lane(0, 7), 8'd0, 1'b1, w);
    n_run++;
    if (bus.out_valid !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL single_lat: got v=%b busy=%b want 1/0", bus.out_valid, bus.busy);
    end
    step();
    n_run++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_once: got %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_k4_bubbles();
    int w;
    bus.out_ready = 1'b1;
    send_beat(lane(1, 1), lane(1, 2), 8'd4, 1'b0, w);
    n_run++;
    if (bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL k4_busy: got %b want 1", bus.busy);
    end
    step();
    step();
    send_beat(lane(1, 3), lane(1, 4), 8'd9, 1'b0, w);
    step();
    send_beat(lane(1, 5), lane(1, 6), 8'd9, 1'b0, w);
    n_run++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL k4_early: got %b want 0", bus.out_valid);
    end
    send_beat(lane(1, 7), lane(1, 8), 8'd9, 1'b1, w);
    n_run++;
    if (bus.out_valid !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL k4_lat: got v=%b busy=%b want 1/0", bus.out_valid, bus.busy);
    end
    step();
    n_run++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL k4_once: got %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    int w;
    int tw;
    res_t e;
    bus.out_ready = 1'b0;
    send_beat(lane(2, 10), lane(2, 20), 8'd1, 1'b1, w);
    e = q[0];
    bus.in_valid = 1'b1;
    bus.sum_in   = lane(2, 50);
    bus.prod_in  = lane(2, 1);
    bus.k_len    = 8'd1;
    for (int c = 0; c < 5; c++) begin
      n_run++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
        n_fail++; $display("FAIL bp_stall%0d: got rdy=%b v=%b want 0/1", c, bus.in_ready, bus.out_valid);
      end
      n_run++;
      if (bus.out_data !== e.data) begin
        n_fail++; $display("FAIL bp_hold%0d: got %h want %h", c, bus.out_data, e.data);
      end
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    n_run++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: got v=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready);
    end
    tw = 0;
    for (int r = 0; r < 3; r++) begin
      send_beat(lane(r, r + 1) | lane(3, 2), lane(3, 1), 8'd2, 1'b0, w);
      tw += w;
      send_beat(lane(r, 10), lane(3, 1), 8'd2, 1'b1, w);
      tw += w;
      n_run++;
      if (bus.out_valid !== 1'b1) begin
        n_fail++; $display("FAIL b2b_valid%0d: got %b want 1", r, bus.out_valid);
      end
    end
    n_run++;
    if (tw != 0) begin
      n_fail++; $display("FAIL b2b_gaps: got %0d stalls want 0", tw);
    end
    step();
  endtask

  task automatic test_overflow();
    int w;
    bus.out_ready = 1'b1;
    send_beat(lane(0, 100) | lane(1, -100),
              lane(0, 27) | lane(1, -28), 8'd2, 1'b0, w);
    send_beat(lane(0, 100) | lane(1, -100),
              lane(0, 27) | lane(1, -28), 8'd2, 1'b1, w);
    n_run++;
`ifdef END_ACC_SATURATE_EN
    if (bus.out_data[15:0] !== 16'h807F || bus.out_ovf !== 4'b0011) begin
      n_fail++; $display("FAIL ovf_sat: got %h/%b want 807f/0011", bus.out_data[15:0], bus.out_ovf);
    end
`else
    if (bus.out_data[15:0] !== 16'h00FE || bus.out_ovf !== 4'b0000) begin
      n_fail++; $display("FAIL ovf_wrap: got %h/%b want 00fe/0000", bus.out_data[15:0], bus.out_ovf);
    end
`endif
    step();
  endtask

  task automatic test_clear();
    int w;
    res_t e;
    bus.out_ready = 1'b0;
    send_beat(lane(3, 3), lane(3, 4), 8'd1, 1'b1, w);
    e = q[0];
    bus.clear    = 1'b1;
    bus.in_valid = 1'b1;
    bus.sum_in   = lane(3, 99);
    step();
    idle_in();
    n_run++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== e.data) begin
      n_fail++; $display("FAIL clr_pending: got v=%b %h want 1 %h", bus.out_valid, bus.out_data, e.data);
    end
    bus.out_ready = 1'b1;
    step();
    send_beat(lane(0, 50), lane(0, 50), 8'd4, 1'b0, w);
    send_beat(lane(0, 50), lane(0, 50), 8'd4, 1'b0, w);
    bus.clear    = 1'b1;
    bus.in_valid = 1'b1;
    bus.sum_in   = lane(0, 77);
    n_run++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL clr_mid: got rdy=%b busy=%b want 1/1", bus.in_ready, bus.busy);
    end
    step();
    idle_in();
    zero_model();
    n_run++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL clr_idle: got busy=%b v=%b want 0/0", bus.busy, bus.out_valid);
    end
    for (int b = 1; b <= 4; b++)
      send_beat(lane(0, b), lane(0, b), 8'd4, b == 4, w);
    step();
  endtask

  task automatic test_reset_mid();
    int w;
    bus.out_ready = 1'b0;
    send_beat(lane(2, 9), lane(2, 9), 8'd1, 1'b1, w);
    #2 rst_n = 1'b0;
    #1;
    n_run++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0) begin
      n_fail++; $display("FAIL arst_out: got v=%b %h want 0 0", bus.out_valid, bus.out_data);
    end
    q.delete();
    zero_model();
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    send_beat(lane(1, 40), lane(1, 40), 8'd3, 1'b0, w);
    send_beat(lane(1, 40), lane(1, 40), 8'd3, 1'b0, w);
    #2 rst_n = 1'b0;
    #1;
    n_run++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL arst_busy: got %b want 0", bus.busy);
    end
    zero_model();
    step();
    rst_n = 1'b1;
    send_beat(lane(1, 1), lane(1, 2), 8'd2, 1'b0, w);
    send_beat(lane(1, 3), lane(1, 4), 8'd2, 1'b1, w);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_k4_bubbles();
    test_backpressure();
    test_overflow();
    test_clear();
    test_reset_mid();
    repeat (3) step();
    n_run++;
    if (q.size() != 0) begin
      n_fail++; $display("FAIL sb_left: got %0d pending want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
